// File: rtl/read_word_if.sv
// ---------------------------------------------------------------------------
// read_word_if
//   Bundles the load-port request/response handshake, the per-way tag/data
//   array read port and the hit/miss statistics of the read_word block.
//
//   slave  modport : the read_word block itself.
//   master modport : the environment (core load port plus way arrays).
//
//   Signals:
//     r_en, word_address, req_ready        request handshake
//     way_rd_en, way_set_index             read strobe/index to every way
//     way_valid, way_tag, way_line         per-way result, 1 cycle later
//     rsp_valid, rsp_ready                 response handshake
//     rsp_data, rsp_hit, rsp_way,
//     rsp_multi_hit                        response payload
//     hit_count, miss_count                saturating statistics
// ---------------------------------------------------------------------------
interface read_word_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int BLOCK_SIZE    = 32,
    parameter int ADDRESS_WIDTH = 32,
    parameter int NUM_WAYS      = 4,
    parameter int NUM_SETS      = 64
);
    localparam int WORDS_PER_BLOCK = BLOCK_SIZE / (DATA_WIDTH / 8);
    localparam int BYTE_OFF_W      = $clog2(DATA_WIDTH / 8);
    localparam int WORD_OFF_W      = $clog2(WORDS_PER_BLOCK);
    localparam int INDEX_W         = $clog2(NUM_SETS);
    localparam int TAG_W           = ADDRESS_WIDTH - INDEX_W - WORD_OFF_W - BYTE_OFF_W;
    localparam int LINE_W          = BLOCK_SIZE * 8;
    localparam int WAY_W           = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

    logic                         r_en;
    logic [ADDRESS_WIDTH-1:0]     word_address;
    logic                         req_ready;
    logic                         way_rd_en;
    logic [INDEX_W-1:0]           way_set_index;
    logic [NUM_WAYS-1:0]          way_valid;
    logic [NUM_WAYS*TAG_W-1:0]    way_tag;
    logic [NUM_WAYS*LINE_W-1:0]   way_line;
    logic                         rsp_valid;
    logic                         rsp_ready;
    logic [DATA_WIDTH-1:0]        rsp_data;
    logic                         rsp_hit;
    logic [WAY_W-1:0]             rsp_way;
    logic                         rsp_multi_hit;
    logic [31:0]                  hit_count;
    logic [31:0]                  miss_count;

    modport slave (
        input  r_en, word_address, way_valid, way_tag, way_line, rsp_ready,
        output req_ready, way_rd_en, way_set_index, rsp_valid, rsp_data,
               rsp_hit, rsp_way, rsp_multi_hit, hit_count, miss_count
    );

    modport master (
        output r_en, word_address, way_valid, way_tag, way_line, rsp_ready,
        input  req_ready, way_rd_en, way_set_index, rsp_valid, rsp_data,
               rsp_hit, rsp_way, rsp_multi_hit, hit_count, miss_count
    );
endinterface

// File: rtl/read_word.sv
// ---------------------------------------------------------------------------
// read_word
//   Single-word cache read path. Accepts one request at a time, reads the
//   addressed set from every way (1-cycle synchronous arrays), compares all
//   tags in parallel and returns the addressed word of the lowest-indexed
//   hitting way, or a miss indication for the fill controller.
//
//   Ports:
//     clk      rising-edge clock
//     reset_n  asynchronous active-low reset
//     bus      read_word_if.slave (request, way array port, response, stats)
//
//   Timing: accept in IDLE (T), way strobe in READ (T+1), compare in
//   COMPARE (T+2), response held in RESP (T+3 onward) until rsp_ready.
// ---------------------------------------------------------------------------
module read_word #(
    parameter int DATA_WIDTH    = 32,
    parameter int BLOCK_SIZE    = 32,
    parameter int ADDRESS_WIDTH = 32,
    parameter int NUM_WAYS      = 4,
    parameter int NUM_SETS      = 64
) (
    input  logic       clk,
    input  logic       reset_n,
    read_word_if.slave bus
);
    localparam int WORDS_PER_BLOCK = BLOCK_SIZE / (DATA_WIDTH / 8);
    localparam int BYTE_OFF_W      = $clog2(DATA_WIDTH / 8);
    localparam int WORD_OFF_W      = $clog2(WORDS_PER_BLOCK);
    localparam int INDEX_W         = $clog2(NUM_SETS);
    localparam int TAG_W           = ADDRESS_WIDTH - INDEX_W - WORD_OFF_W - BYTE_OFF_W;
    localparam int LINE_W          = BLOCK_SIZE * 8;
    localparam int WAY_W           = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
    localparam int ADDR_KEEP_W     = ADDRESS_WIDTH - BYTE_OFF_W;

    typedef enum logic [1:0] {S_IDLE, S_READ, S_COMPARE, S_RESP} state_t;

    state_t                   r_state;
    state_t                   w_state_next;

    // Byte offset is never needed, so only the word-aligned part is latched.
    logic [ADDR_KEEP_W-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]    r_rsp_data;
    logic                     r_rsp_hit;
    logic [WAY_W-1:0]         r_rsp_way;
    logic                     r_rsp_multi_hit;
    logic [31:0]              r_hit_count;
    logic [31:0]              r_miss_count;

    logic [TAG_W-1:0]         w_tag;
    logic [INDEX_W-1:0]       w_index;
    logic [WORD_OFF_W-1:0]    w_word_off;
    logic [NUM_WAYS-1:0]      w_hit;
    logic                     w_any_hit;
    logic                     w_multi_hit;
    logic [WAY_W-1:0]         w_sel_way;
    logic [LINE_W-1:0]        w_sel_line;
    logic [DATA_WIDTH-1:0]    w_sel_word;
    logic                     w_req_ready;
    logic                     w_way_rd_en;
    logic                     w_rsp_valid;
    logic                     w_unused_byte_off;

    assign w_tag      = r_addr[ADDR_KEEP_W-1 -: TAG_W];
    assign w_index    = r_addr[WORD_OFF_W +: INDEX_W];
    assign w_word_off = r_addr[WORD_OFF_W-1:0];

    assign w_unused_byte_off = ^bus.word_address[BYTE_OFF_W-1:0];

    // ---------------------------------------------------------------------
    // Parallel tag compare across all ways. The descending loop leaves the
    // lowest-indexed hit as the selected way; with no hit the selection and
    // line stay zero, which is exactly the miss response.
    // ---------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned; otherwise synthesis infers a latch.
        w_hit      = '0;
        w_sel_way  = '0;
        w_sel_line = '0;
        w_sel_word = '0;
        for (int i = 0; i < NUM_WAYS; i++) begin
            w_hit[i] = bus.way_valid[i] && (bus.way_tag[i*TAG_W +: TAG_W] == w_tag);
        end
        for (int i = NUM_WAYS - 1; i >= 0; i--) begin
            if (w_hit[i]) begin
                w_sel_way  = WAY_W'(i);
                w_sel_line = bus.way_line[i*LINE_W +: LINE_W];
            end
        end
        for (int k = 0; k < WORDS_PER_BLOCK; k++) begin
            if (w_word_off == WORD_OFF_W'(k)) begin
                w_sel_word = w_sel_line[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign w_any_hit   = |w_hit;
    // Clearing the lowest set bit leaves something only if two or more hit.
    assign w_multi_hit = |(w_hit & (w_hit - NUM_WAYS'(1)));

    // ---------------------------------------------------------------------
    // FSM: next state and handshake outputs.
    // ---------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_req_ready  = 1'b0;
        w_way_rd_en  = 1'b0;
        w_rsp_valid  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_req_ready = 1'b1;
                if (bus.r_en) w_state_next = S_READ;
            end
            S_READ: begin
                w_way_rd_en  = 1'b1;
                w_state_next = S_COMPARE;
            end
            S_COMPARE: begin
                w_state_next = S_RESP;
            end
            S_RESP: begin
                w_rsp_valid = 1'b1;
                if (bus.rsp_ready) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_addr          <= '0;
            r_rsp_data      <= '0;
            r_rsp_hit       <= 1'b0;
            r_rsp_way       <= '0;
            r_rsp_multi_hit <= 1'b0;
            r_hit_count     <= '0;
            r_miss_count    <= '0;
        end else begin
            if (r_state == S_IDLE && bus.r_en) begin
                r_addr <= bus.word_address[ADDRESS_WIDTH-1:BYTE_OFF_W];
            end
            if (r_state == S_COMPARE) begin
                r_rsp_data      <= w_sel_word;
                r_rsp_hit       <= w_any_hit;
                r_rsp_way       <= w_sel_way;
                r_rsp_multi_hit <= w_multi_hit;
                if (w_any_hit) begin
                    if (r_hit_count != '1) r_hit_count <= r_hit_count + 32'd1;
                end else begin
                    if (r_miss_count != '1) r_miss_count <= r_miss_count + 32'd1;
                end
            end
        end
    end

    assign bus.req_ready     = w_req_ready;
    assign bus.way_rd_en     = w_way_rd_en;
    assign bus.way_set_index = w_index;
    assign bus.rsp_valid     = w_rsp_valid;
    assign bus.rsp_data      = r_rsp_data;
    assign bus.rsp_hit       = r_rsp_hit;
    assign bus.rsp_way       = r_rsp_way;
    assign bus.rsp_multi_hit = r_rsp_multi_hit;
    assign bus.hit_count     = r_hit_count;
    assign bus.miss_count    = r_miss_count;
endmodule
